simplebus_mem_target: RTL and testbench
=======================================

Name: simplebus_mem_target

Overview:
Synthesizable, parametrised external simplebus target that replaces the fixed-response bus model with a real word-addressed backing memory. It decodes byte-serial READ/WRITE commands from the bus master, honours write byte-selects, and returns read data after a programmable delay. It also adds parity-error NAK, out-of-range address handling and error counting. It sits on the board/FPGA side of the Microwatt external bus, one clock domain.

Parameters:
ADDR_BYTES, 4, address bytes per command (1..4), LSB first
DATA_BYTES, 8, data bytes per word (2,4,8); sel byte has DATA_BYTES valid bits
MEM_DEPTH, 256, words of backing memory (power of 2)
READ_DELAY, 8, cycles from last read-address byte to READ_ACK (1..15)

Ports:
clk  in  1  bus clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
bus_in  in  8  byte from master
bus_pty_in  in  1  odd parity for bus_in (must equal ~^bus_in)
bus_out  out  8  registered byte to master
bus_pty_out  out  1  ~^bus_out
busy  out  1  high whenever state != IDLE
parity_err_count  out  16  saturating count of parity errors
range_err  out  1  one-cycle pulse on out-of-range access

Behaviour:
- Reset (async, any time incl. mid-transaction): state IDLE, bus_out=0, bus_pty_out=1, busy=0, parity_err_count=0, range_err=0, counters/shift regs cleared; memory contents not reset (undefined until written).
- Commands: 0x02 READ, 0x03 WRITE. Responses: 0x82 READ_ACK, 0x83 WRITE_ACK, 0xFF NAK. 0x00 = idle bus.
- States: IDLE, W_ADDR, W_SEL, W_DATA, R_ADDR, R_DELAY, TX.
- IDLE: bus_in=0x03 -> W_ADDR; 0x02 -> R_ADDR; count=ADDR_BYTES; addr/data/sel cleared. Other nonzero bytes ignored.
- W_ADDR/R_ADDR: addr shifts in LSB first, one byte per cycle; after ADDR_BYTES bytes -> W_SEL, or R_DELAY with count=READ_DELAY.
- W_SEL: one byte, low DATA_BYTES bits kept -> W_DATA, count=DATA_BYTES.
- W_DATA: data LSB first; on the final byte edge, memory write of bytes whose sel bit is 1, others unchanged; TX queue = {0x83}.
- R_DELAY: counts down; on final count memory read completes, TX queue = {0x82, d[7:0], ..., d[8*DATA_BYTES-1 -:8]}.
- Latency: write: last data byte sampled at edge N -> bus_out=0x83 from edge N+1, 0 from N+2. Read: last addr byte at edge N -> 0x82 from edge N+READ_DELAY+1, data bytes on following DATA_BYTES consecutive cycles, then 0.
- TX: one byte per cycle; bus_in ignored (no parity check, commands dropped) while in TX; returns to IDLE on same edge last byte is driven; bus_out=0 outside TX.
- Word index = addr >> log2(DATA_BYTES); low address bits ignored. Index >= MEM_DEPTH: write discarded but still ACKed; read returns all-zero data; range_err pulses one cycle at the edge the ack is queued.
- Parity: checked every cycle in IDLE, W_*, R_ADDR. Error in IDLE -> count only, stay IDLE. Error in W_*/R_ADDR -> abort, memory untouched, TX queue={0xFF}, count++. R_DELAY ignores bus_in. Counter saturates at 0xFFFF.
- bus_pty_out always combinationally ~^bus_out.

Test Plan:
- WRITE addr 0x00000010, sel 0xFF, data 0x0102030405060708 -> 0x83 one cycle after last data byte; READ same addr -> 0x82 at N+9 then 08,07,06,05,04,03,02,01, then 00.
- WRITE addr 0x10 sel 0x0F data 0xAAAAAAAAAAAAAAAA over prior word -> READ returns 0x01020304AAAAAAAA.
- READ addr 0x00000800 (index 256) -> 0x82 + eight 0x00, range_err pulse; WRITE same -> 0x83, no memory change.
- Flip parity on 3rd address byte of WRITE -> 0xFF NAK next cycle, parity_err_count=1, target word unchanged; bad parity on 0x00 in IDLE -> count=2, no response.
- Assert rst during R_DELAY -> bus_out=0, busy=0 immediately; following WRITE/READ completes normally.
- Send 0x03 on bus_in while read data is transmitting -> ignored; response bytes unchanged, IDLE afterwards.

Source files
------------

// File: rtl/simplebus_mem_target.sv
// simplebus target backed by a word-addressed memory: byte-serial READ/WRITE decode,
// byte-select writes, delayed read data, parity NAK and out-of-range handling.
module simplebus_mem_target #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int READ_DELAY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  bus_in,
    input  logic        bus_pty_in,
    output logic [7:0]  bus_out,
    output logic        bus_pty_out,
    output logic        busy,
    output logic [15:0] parity_err_count,
    output logic        range_err
);
    localparam int AW  = 8 * ADDR_BYTES;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int TXW = DW + 8;
    localparam int OFS = $clog2(DATA_BYTES);
    localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;
    localparam logic [7:0] RSP_READ  = 8'h82;
    localparam logic [7:0] RSP_WRITE = 8'h83;
    localparam logic [7:0] RSP_NAK   = 8'hFF;

    typedef enum logic [2:0] {IDLE, W_ADDR, W_SEL, W_DATA, R_ADDR, R_DELAY, TX} state_t;

    state_t                state;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         data;
    logic [DATA_BYTES-1:0] sel;
    logic [3:0]            cnt;
    logic [TXW-1:0]        tx_buf;
    logic [3:0]            tx_cnt;
    logic [DW-1:0]         mem [MEM_DEPTH];

    logic           pty_ok, last, in_range, mem_we;
    logic [AW-1:0]  addr_nxt;
    logic [DW-1:0]  data_nxt, rd_word;
    logic [AW+31:0] widx;
    logic [MAW-1:0] midx;
    logic [15:0]    pec_inc;

    assign pty_ok   = (bus_pty_in == ~^bus_in);
    assign last     = (cnt == 4'd1);
    // Fields arrive LSB first: each byte enters at the top and shifts down.
    assign addr_nxt = (addr >> 8) | (AW'(bus_in) << (AW - 8));
    assign data_nxt = (data >> 8) | (DW'(bus_in) << (DW - 8));
    assign widx     = {32'b0, addr} >> OFS;
    assign in_range = (widx < (AW + 32)'(MEM_DEPTH));
    assign midx     = widx[MAW-1:0];
    assign rd_word  = in_range ? mem[midx] : '0;
    assign mem_we   = (state == W_DATA) && last && pty_ok && in_range;
    assign pec_inc  = (parity_err_count == 16'hFFFF) ? parity_err_count
                                                     : parity_err_count + 16'd1;

    assign busy        = (state != IDLE);
    assign bus_pty_out = ~^bus_out;

    // Backing store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (sel[b]) mem[midx][8*b +: 8] <= data_nxt[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            addr             <= '0;
            data             <= '0;
            sel              <= '0;
            cnt              <= '0;
            tx_buf           <= '0;
            tx_cnt           <= '0;
            bus_out          <= 8'h00;
            parity_err_count <= 16'h0000;
            range_err        <= 1'b0;
        end else begin
            range_err <= 1'b0;
            bus_out   <= 8'h00;
            case (state)
                IDLE: begin
                    if (!pty_ok) begin
                        parity_err_count <= pec_inc;
                    end else if (bus_in == CMD_WRITE || bus_in == CMD_READ) begin
                        state <= (bus_in == CMD_WRITE) ? W_ADDR : R_ADDR;
                        cnt   <= 4'(ADDR_BYTES);
                        addr  <= '0;
                        data  <= '0;
                        sel   <= '0;
                    end
                end
                W_ADDR, R_ADDR, W_SEL, W_DATA: begin
                    if (!pty_ok) begin
                        // Abort the command and answer with a single NAK.
                        parity_err_count <= pec_inc;
                        tx_buf           <= TXW'(RSP_NAK);
                        tx_cnt           <= 4'd1;
                        state            <= TX;
                    end else if (state == W_SEL) begin
                        sel   <= bus_in[DATA_BYTES-1:0];
                        cnt   <= 4'(DATA_BYTES);
                        state <= W_DATA;
                    end else if (state == W_DATA) begin
                        data <= data_nxt;
                        cnt  <= cnt - 4'd1;
                        if (last) begin
                            tx_buf    <= TXW'(RSP_WRITE);
                            tx_cnt    <= 4'd1;
                            range_err <= !in_range;
                            state     <= TX;
                        end
                    end else begin
                        addr <= addr_nxt;
                        cnt  <= cnt - 4'd1;
                        if (last) begin
                            if (state == W_ADDR) begin
                                state <= W_SEL;
                            end else begin
                                state <= R_DELAY;
                                cnt   <= 4'(READ_DELAY);
                            end
                        end
                    end
                end
                R_DELAY: begin
                    cnt <= cnt - 4'd1;
                    if (last) begin
                        tx_buf    <= {rd_word, RSP_READ};
                        tx_cnt    <= 4'(DATA_BYTES + 1);
                        range_err <= !in_range;
                        state     <= TX;
                    end
                end
                TX: begin
                    bus_out <= tx_buf[7:0];
                    tx_buf  <= tx_buf >> 8;
                    tx_cnt  <= tx_cnt - 4'd1;
                    if (tx_cnt == 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simplebus_mem_target.sv
// Self-checking bench for simplebus_mem_target: directed scenarios plus random
// traffic checked against a word-array memory model and byte-stream expectations.
module tb_simplebus_mem_target;
    localparam int RD    = 8;
    localparam int DEPTH = 256;
    localparam int CAPN  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bus_in = 8'h00;
    logic        bus_pty_in = 1'b1;
    logic [7:0]  bus_out;
    logic        bus_pty_out;
    logic        busy;
    logic [15:0] parity_err_count;
    logic        range_err;

    always #5 clk = ~clk;

    simplebus_mem_target #(
        .ADDR_BYTES(4), .DATA_BYTES(8), .MEM_DEPTH(DEPTH), .READ_DELAY(RD)
    ) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .bus_pty_in(bus_pty_in),
        .bus_out(bus_out), .bus_pty_out(bus_pty_out), .busy(busy),
        .parity_err_count(parity_err_count), .range_err(range_err)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl [DEPTH];
    logic [7:0]  sq [$];
    logic [7:0]  cap [CAPN];
    logic        cap_p [CAPN];
    logic        cap_r [CAPN];
    logic        cap_b [CAPN];
    logic [7:0]  expb [CAPN];
    int          exp_rng_at;
    logic [15:0] pec_exp = 16'h0000;
    int          written [$];

    function automatic bit oob(input logic [31:0] a);
        return (a >> 3) >= DEPTH;
    endfunction

    task automatic mk_write(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
        sq = {};
        sq.push_back(8'h03);
        for (int k = 0; k < 4; k++) sq.push_back(a[8*k +: 8]);
        sq.push_back(s);
        for (int k = 0; k < 8; k++) sq.push_back(d[8*k +: 8]);
    endtask

    task automatic mk_read(input logic [31:0] a);
        sq = {};
        sq.push_back(8'h02);
        for (int k = 0; k < 4; k++) sq.push_back(a[8*k +: 8]);
    endtask

    task automatic send_seq(input int bad_at);
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            bus_in     = sq[i];
            bus_pty_in = (i == bad_at) ? ^sq[i] : ~^sq[i];
            if (i == bad_at) break;
        end
    endtask

    // cap[i] is the output after the (i+1)th edge following the last command byte.
    task automatic capture(input int inj_at, input logic [7:0] inj_val);
        for (int i = 0; i < CAPN; i++) begin
            @(negedge clk);
            cap[i]   = bus_out;
            cap_p[i] = bus_pty_out;
            cap_r[i] = range_err;
            cap_b[i] = busy;
            bus_in     = (i == inj_at) ? inj_val : 8'h00;
            bus_pty_in = ~^bus_in;
        end
    endtask

    task automatic exp_single(input logic [7:0] rsp, input bit pulse);
        for (int i = 0; i < CAPN; i++) expb[i] = 8'h00;
        expb[1]    = rsp;
        exp_rng_at = pulse ? 0 : -1;
    endtask

    task automatic exp_read_word(input logic [63:0] w, input bit is_oob);
        for (int i = 0; i < CAPN; i++) expb[i] = 8'h00;
        expb[RD+1] = 8'h82;
        for (int k = 0; k < 8; k++) expb[RD+2+k] = is_oob ? 8'h00 : w[8*k +: 8];
        exp_rng_at = is_oob ? RD : -1;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
        if (!oob(a)) begin
            for (int k = 0; k < 8; k++)
                if (s[k]) mdl[a >> 3][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
        mk_write(a, s, d);
        send_seq(-1);
        model_write(a, s, d);
        exp_single(8'h83, oob(a));
        capture(-1, 8'h00);
    endtask

    task automatic do_read(input logic [31:0] a);
        mk_read(a);
        send_seq(-1);
        exp_read_word(oob(a) ? 64'h0 : mdl[a >> 3], oob(a));
        capture(-1, 8'h00);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus_out !== 8'h00 || bus_pty_out !== 1'b1 || busy !== 1'b0 ||
            parity_err_count !== 16'h0 || range_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%h pty=%b busy=%b pec=%0d rng=%b, want 00/1/0/0/0",
                     bus_out, bus_pty_out, busy, parity_err_count, range_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        do_write(32'h10, 8'hFF, 64'h0102030405060708);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i] || cap_p[i] !== ~^expb[i] || cap_r[i] !== (i == exp_rng_at)) begin
                errors++;
                $display("FAIL wr_ack[%0d]: got %h/%b/%b, want %h/%b/%b", i, cap[i], cap_p[i], cap_r[i],
                         expb[i], ~^expb[i], i == exp_rng_at);
            end
        end
        mk_read(32'h10);
        send_seq(-1);
        exp_read_word(64'h0102030405060708, 1'b0);
        capture(-1, 8'h00);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i] || cap_p[i] !== ~^expb[i] || cap_r[i] !== (i == exp_rng_at)) begin
                errors++;
                $display("FAIL rd_data[%0d]: got %h/%b/%b, want %h/%b/%b", i, cap[i], cap_p[i], cap_r[i],
                         expb[i], ~^expb[i], i == exp_rng_at);
            end
        end
        checks++;
        if (cap_b[RD] !== 1'b1 || cap_b[CAPN-1] !== 1'b0) begin
            errors++;
            $display("FAIL rd_busy: got %b,%b want 1,0", cap_b[RD], cap_b[CAPN-1]);
        end
    endtask

    task automatic test_byte_select;
        do_write(32'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        mk_read(32'h13);
        send_seq(-1);
        exp_read_word(64'h01020304AAAAAAAA, 1'b0);
        capture(-1, 8'h00);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i] || cap_r[i] !== (i == exp_rng_at)) begin
                errors++;
                $display("FAIL sel_rd[%0d]: got %h/%b, want %h/%b", i, cap[i], cap_r[i],
                         expb[i], i == exp_rng_at);
            end
        end
    endtask

    task automatic test_out_of_range;
        do_write(32'h0, 8'hFF, 64'hCAFEF00D12345678);
        do_read(32'h800);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i] || cap_r[i] !== (i == exp_rng_at)) begin
                errors++;
                $display("FAIL oob_rd[%0d]: got %h/%b, want %h/%b", i, cap[i], cap_r[i],
                         expb[i], i == exp_rng_at);
            end
        end
        do_write(32'h800, 8'hFF, 64'h1111111111111111);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i] || cap_r[i] !== (i == exp_rng_at)) begin
                errors++;
                $display("FAIL oob_wr[%0d]: got %h/%b, want %h/%b", i, cap[i], cap_r[i],
                         expb[i], i == exp_rng_at);
            end
        end
        do_read(32'h0);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i]) begin
                errors++;
                $display("FAIL oob_alias[%0d]: got %h, want %h", i, cap[i], expb[i]);
            end
        end
    endtask

    task automatic test_parity;
        do_write(32'h40, 8'hFF, 64'h0F0E0D0C0B0A0908);
        mk_write(32'h40, 8'hFF, 64'h5555555555555555);
        send_seq(3);
        pec_exp++;
        exp_single(8'hFF, 1'b0);
        capture(-1, 8'h00);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i] || cap_p[i] !== ~^expb[i]) begin
                errors++;
                $display("FAIL nak[%0d]: got %h/%b, want %h/%b", i, cap[i], cap_p[i], expb[i], ~^expb[i]);
            end
        end
        checks++;
        if (parity_err_count !== pec_exp) begin
            errors++;
            $display("FAIL pec_nak: got %0d want %0d", parity_err_count, pec_exp);
        end
        do_read(32'h40);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i]) begin
                errors++;
                $display("FAIL nak_unchanged[%0d]: got %h want %h", i, cap[i], expb[i]);
            end
        end
        @(negedge clk);
        bus_in = 8'h00;
        bus_pty_in = 1'b0;
        pec_exp++;
        for (int i = 0; i < CAPN; i++) expb[i] = 8'h00;
        capture(-1, 8'h00);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== 8'h00 || cap_b[i] !== 1'b0) begin
                errors++;
                $display("FAIL idle_pty[%0d]: got %h busy %b, want 00 busy 0", i, cap[i], cap_b[i]);
            end
        end
        checks++;
        if (parity_err_count !== pec_exp) begin
            errors++;
            $display("FAIL pec_idle: got %0d want %0d", parity_err_count, pec_exp);
        end
    endtask

    task automatic test_reset_mid_read;
        do_write(32'h18, 8'hFF, {$urandom, $urandom});
        mk_read(32'h18);
        send_seq(-1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_in = 8'h00;
            bus_pty_in = 1'b1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL delay_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        pec_exp = 16'h0;
        #1;
        checks++;
        if (bus_out !== 8'h00 || busy !== 1'b0 || parity_err_count !== pec_exp) begin
            errors++;
            $display("FAIL rst_mid: out=%h busy=%b pec=%0d, want 00/0/0", bus_out, busy, parity_err_count);
        end
        @(negedge clk);
        rst = 1'b0;
        do_write(32'h18, 8'hFF, 64'h0123456789ABCDEF);
        do_read(32'h18);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i]) begin
                errors++;
                $display("FAIL post_rst_rd[%0d]: got %h want %h", i, cap[i], expb[i]);
            end
        end
    endtask

    task automatic test_tx_ignore;
        mk_read(32'h10);
        send_seq(-1);
        exp_read_word(mdl[2], 1'b0);
        capture(RD + 3, 8'h03);
        for (int i = 0; i < CAPN; i++) begin
            checks++;
            if (cap[i] !== expb[i]) begin
                errors++;
                $display("FAIL tx_ignore[%0d]: got %h want %h", i, cap[i], expb[i]);
            end
        end
        checks++;
        if (cap_b[CAPN-1] !== 1'b0) begin
            errors++;
            $display("FAIL tx_ignore_idle: busy %b want 0", cap_b[CAPN-1]);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        int          idx, r;
        bit          is_write;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = ($urandom_range(DEPTH, 65535) << 3) | $urandom_range(0, 7);
                is_write = $urandom_range(0, 1) == 1;
            end else if (r < 5 || written.size() == 0) begin
                idx = $urandom_range(0, DEPTH - 1);
                a = (idx << 3) | $urandom_range(0, 7);
                is_write = 1'b1;
            end else begin
                idx = written[$urandom_range(0, written.size() - 1)];
                a = (idx << 3) | $urandom_range(0, 7);
                is_write = 1'b0;
            end
            if (is_write) begin
                if (!oob(a) && !(written.size() > 0 && (a >> 3) inside {written})) begin
                    written.push_back(a >> 3);
                    do_write(a, 8'hFF, {$urandom, $urandom});
                end else begin
                    do_write(a, 8'($urandom), {$urandom, $urandom});
                end
            end else begin
                do_read(a);
            end
            for (int i = 0; i < CAPN; i++) begin
                checks++;
                if (cap[i] !== expb[i] || cap_p[i] !== ~^expb[i] || cap_r[i] !== (i == exp_rng_at)) begin
                    errors++;
                    $display("FAIL rand %0d %s a=%h [%0d]: got %h/%b/%b, want %h/%b/%b", n,
                             is_write ? "wr" : "rd", a, i, cap[i], cap_p[i], cap_r[i],
                             expb[i], ~^expb[i], i == exp_rng_at);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 64'h0;
        test_reset;
        test_write_read;
        test_byte_select;
        test_out_of_range;
        test_parity;
        test_reset_mid_read;
        test_tx_ignore;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
